da3ctl: RTL and testbench

- Sample scheduler and arbiter in front of the DA3 16-bit serial DAC serializer.
- Paces DAC updates from a programmable sample-rate divider.
- Shares the single DAC between two sample requesters using round-robin arbitration.
- Drives the serializer's dacdav/dacdata handshake and monitors davdac, with timeout and overrun reporting.

---
 rtl/da3ctl.sv | 116 +++++++++++
 tb/tb_da3ctl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da3ctl.sv
`default_nettype none
// ============================================================================
// Module   : da3ctl
// Purpose  : Sample-rate paced, round-robin arbitrated front end that feeds
//            the DA3 serial DAC serializer through the dacdav/davdac handshake.
// Revision : 1.0
// ============================================================================
module da3ctl #(
    parameter int RATEDIV = 100,
    parameter int TMO     = 64
) (
    input  logic        dacclk,
    input  logic        dacrst,
    input  logic        dacen,
    input  logic        req0,
    input  logic [15:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        ack1,
    output logic        dacdav,
    output logic [15:0] dacdata,
    input  logic        davdac,
    output logic        busy,
    output logic        lastsrc,
    output logic [7:0]  ovrcnt,
    output logic        tmoerr
);

    localparam int c_cntw = $clog2(RATEDIV + 1);
    localparam int c_tmow = $clog2(TMO + 1);
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(RATEDIV - 1);
    localparam logic [c_tmow-1:0] c_tmo_last = c_tmow'(TMO - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_rel  = 2'd2;

    logic [1:0]        r_state;
    logic [c_cntw-1:0] r_cnt;
    logic [c_tmow-1:0] r_tmo;

    logic w_tick;
    logic w_grant;
    logic w_pick;
    logic w_tmo_hit;

    assign w_tick    = dacen && (r_cnt == c_cnt_last);
    // davdac still high means the serializer has not released the last word yet
    assign w_grant   = (r_state == c_st_idle) && w_tick && !davdac && (req0 || req1);
    assign w_pick    = (req0 && req1) ? ~lastsrc : req1;
    assign w_tmo_hit = (r_tmo == c_tmo_last);
    assign busy      = (r_state != c_st_idle);

    always_ff @(posedge dacclk) begin
        if (dacrst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_tmo   <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            dacdav  <= 1'b0;
            dacdata <= 16'h0000;
            lastsrc <= 1'b1;
            ovrcnt  <= 8'h00;
            tmoerr  <= 1'b0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            r_cnt <= (!dacen || w_tick) ? '0 : r_cnt + 1'b1;

            // A tick arriving while a transfer is in flight is lost
            if (w_tick && (r_state != c_st_idle) && (ovrcnt != 8'hFF)) begin
                ovrcnt <= ovrcnt + 8'd1;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_grant) begin
                        dacdata <= w_pick ? data1 : data0;
                        ack0    <= ~w_pick;
                        ack1    <= w_pick;
                        lastsrc <= w_pick;
                        dacdav  <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    // Completion takes priority over a coincident timeout
                    if (davdac) begin
                        dacdav  <= 1'b0;
                        r_state <= c_st_rel;
                    end else if (w_tmo_hit) begin
                        dacdav  <= 1'b0;
                        tmoerr  <= 1'b1;
                        r_state <= c_st_rel;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_st_rel: begin
                    if (!davdac) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    dacdav  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_da3ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_da3ctl
// Purpose  : Directed bench for da3ctl with a serializer stub and a cycle model.
// Revision : 1.0
// ============================================================================
module tb_da3ctl;

    localparam int RATEDIV = 100;
    localparam int TMO     = 64;

    logic        dacclk = 1'b0;
    logic        dacrst = 1'b0;
    logic        dacen  = 1'b1;
    logic        req0   = 1'b0;
    logic [15:0] data0  = 16'h0000;
    logic        ack0;
    logic        req1   = 1'b0;
    logic [15:0] data1  = 16'h0000;
    logic        ack1;
    logic        dacdav;
    logic [15:0] dacdata;
    logic        davdac = 1'b0;
    logic        busy;
    logic        lastsrc;
    logic [7:0]  ovrcnt;
    logic        tmoerr;

    da3ctl #(.RATEDIV(RATEDIV), .TMO(TMO)) u_dut (
        .dacclk (dacclk),
        .dacrst (dacrst),
        .dacen  (dacen),
        .req0   (req0),
        .data0  (data0),
        .ack0   (ack0),
        .req1   (req1),
        .data1  (data1),
        .ack1   (ack1),
        .dacdav (dacdav),
        .dacdata(dacdata),
        .davdac (davdac),
        .busy   (busy),
        .lastsrc(lastsrc),
        .ovrcnt (ovrcnt),
        .tmoerr (tmoerr)
    );

    always #5 dacclk = ~dacclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Serializer stub: answers dacdav with davdac after stub_lat cycles, holds it stub_hold cycles
    int stub_lat   = 34;
    int stub_hold  = 2;
    bit stub_never = 1'b0;
    int stub_cnt   = 0;
    bit stub_on    = 1'b0;

    always @(negedge dacclk) begin
        if (!stub_on) begin
            if (dacdav && !stub_never) begin
                stub_cnt++;
                if (stub_cnt >= stub_lat) begin
                    davdac   = 1'b1;
                    stub_on  = 1'b1;
                    stub_cnt = 0;
                end
            end else begin
                stub_cnt = 0;
            end
        end else begin
            stub_cnt++;
            if (stub_cnt >= stub_hold) begin
                davdac   = 1'b0;
                stub_on  = 1'b0;
                stub_cnt = 0;
            end
        end
    end

    // Behavioural model: a transfer is "held" from grant until done/timeout, then
    // "released" until davdac drops; timeout measured as edges since dacdav rose.
    bit          m_valid = 1'b0;
    longint      cyc     = 0;
    longint      m_rise  = 0;
    int          m_pos   = 0;
    bit          m_hold  = 1'b0;
    bit          m_rel   = 1'b0;
    bit          m_ack0  = 1'b0;
    bit          m_ack1  = 1'b0;
    bit          m_last  = 1'b1;
    bit          m_tmo   = 1'b0;
    int          m_ovr   = 0;
    logic [15:0] m_data  = 16'h0000;
    bit          m_tick;
    bit          m_pick;

    always @(posedge dacclk) begin
        cyc++;
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        if (dacrst) begin
            m_valid = 1'b1;
            m_pos   = 0;
            m_hold  = 1'b0;
            m_rel   = 1'b0;
            m_data  = 16'h0000;
            m_last  = 1'b1;
            m_ovr   = 0;
            m_tmo   = 1'b0;
        end else if (m_valid) begin
            m_tick = dacen && (m_pos == RATEDIV - 1);
            m_pos  = (!dacen || m_tick) ? 0 : m_pos + 1;
            if (m_hold || m_rel) begin
                if (m_tick && m_ovr < 255) m_ovr++;
                if (m_hold) begin
                    if (davdac) begin
                        m_hold = 1'b0;
                        m_rel  = 1'b1;
                    end else if (cyc - m_rise == TMO) begin
                        m_hold = 1'b0;
                        m_rel  = 1'b1;
                        m_tmo  = 1'b1;
                    end
                end else if (!davdac) begin
                    m_rel = 1'b0;
                end
            end else if (m_tick && !davdac && (req0 || req1)) begin
                m_pick = (req0 && req1) ? !m_last : req1;
                m_data = m_pick ? data1 : data0;
                m_ack0 = !m_pick;
                m_ack1 = m_pick;
                m_last = m_pick;
                m_hold = 1'b1;
                m_rise = cyc;
            end
        end
    end

    always @(negedge dacclk) begin
        if (m_valid) begin
            chk("ack0",    32'(ack0),    32'(m_ack0));
            chk("ack1",    32'(ack1),    32'(m_ack1));
            chk("dacdav",  32'(dacdav),  32'(m_hold));
            chk("dacdata", 32'(dacdata), 32'(m_data));
            chk("busy",    32'(busy),    32'(m_hold || m_rel));
            chk("lastsrc", 32'(lastsrc), 32'(m_last));
            chk("ovrcnt",  32'(ovrcnt),  32'(m_ovr));
            chk("tmoerr",  32'(tmoerr),  32'(m_tmo));
        end
    end

    task automatic do_reset();
        @(negedge dacclk);
        dacrst = 1'b1;
        @(negedge dacclk);
        @(negedge dacclk);
        dacrst = 1'b0;
    endtask

    task automatic wait_ack(input int lim, output int n, output int src);
        n   = 0;
        src = -1;
        while (n < lim && src < 0) begin
            @(negedge dacclk);
            n++;
            if (ack0) src = 0;
            else if (ack1) src = 1;
        end
        if (src < 0) chk("ack_timeout", 32'(n), 32'(0));
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (n < lim && busy !== 1'b0) begin
            @(negedge dacclk);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'(0));
    endtask

    int n, src, cnt;
    logic [15:0] exp_data [4];

    initial begin
        // Single transfer from req0
        stub_lat = 34; stub_hold = 2;
        req0 = 1'b1; data0 = 16'hA5C3;
        do_reset();
        wait_ack(300, n, src);
        chk("t1_latency", 32'(n), 32'd100);
        chk("t1_src", 32'(src), 32'd0);
        chk("t1_data", 32'(dacdata), 32'h0000A5C3);
        chk("t1_dav", 32'(dacdav), 32'd1);
        req0 = 1'b0;
        wait_idle(100);

        // Tie alternation
        exp_data[0] = 16'h1111; exp_data[1] = 16'h2222;
        exp_data[2] = 16'h1111; exp_data[3] = 16'h2222;
        req0 = 1'b1; data0 = 16'h1111;
        req1 = 1'b1; data1 = 16'h2222;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_ack(300, n, src);
            chk("t2_spacing", 32'(n), 32'd100);
            chk("t2_src", 32'(src), 32'(i % 2));
            chk("t2_data", 32'(dacdata), 32'(exp_data[i]));
            chk("t2_lastsrc", 32'(lastsrc), 32'(i % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(100);

        // Overrun: long davdac keeps the block in release across a tick
        stub_lat = 10; stub_hold = 150;
        req0 = 1'b1; data0 = 16'h5A5A;
        do_reset();
        wait_ack(300, n, src);
        chk("t3_first", 32'(n), 32'd100);
        for (int i = 0; i < 2; i++) begin
            wait_ack(400, n, src);
            chk("t3_spacing", 32'(n), 32'd200);
        end
        chk("t3_ovr2", 32'(ovrcnt), 32'd2);
        stub_hold = 100000;
        repeat (26000) @(negedge dacclk);
        chk("t3_sat", 32'(ovrcnt), 32'd255);
        chk("t3_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        stub_hold = 2;
        wait_idle(50);

        // Timeout: serializer never answers
        stub_lat = 34; stub_never = 1'b1;
        req0 = 1'b1; data0 = 16'h0BEE;
        do_reset();
        wait_ack(300, n, src);
        chk("t4_latency", 32'(n), 32'd100);
        n = 0;
        while (n < 200 && dacdav === 1'b1) begin
            @(negedge dacclk);
            n++;
        end
        chk("t4_tmo_cycles", 32'(n), 32'd64);
        chk("t4_tmoerr", 32'(tmoerr), 32'd1);
        stub_never = 1'b0;
        wait_ack(300, n, src);
        chk("t4_retry", 32'(n), 32'd36);
        chk("t4_retry_src", 32'(src), 32'd0);
        req0 = 1'b0;
        wait_idle(100);
        chk("t4_sticky", 32'(tmoerr), 32'd1);

        // Reset in the middle of a transfer
        req0 = 1'b1; data0 = 16'h3333;
        req1 = 1'b1; data1 = 16'h4444;
        do_reset();
        wait_ack(300, n, src);
        chk("t5_src", 32'(src), 32'd0);
        repeat (9) @(negedge dacclk);
        dacrst = 1'b1;
        @(negedge dacclk);
        dacrst = 1'b0;
        chk("t5_dav", 32'(dacdav), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ovr", 32'(ovrcnt), 32'd0);
        chk("t5_lastsrc", 32'(lastsrc), 32'd1);
        wait_ack(300, n, src);
        chk("t5_latency", 32'(n), 32'd100);
        chk("t5_tie_src", 32'(src), 32'd0);
        chk("t5_data", 32'(dacdata), 32'h00003333);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(100);

        // Disabled scheduler
        dacen = 1'b0;
        req1 = 1'b1; data1 = 16'hC0DE;
        do_reset();
        cnt = 0;
        repeat (300) begin
            @(negedge dacclk);
            if (ack1 || dacdav) cnt++;
        end
        chk("t6_quiet", 32'(cnt), 32'd0);
        dacen = 1'b1;
        wait_ack(300, n, src);
        chk("t6_latency", 32'(n), 32'd100);
        chk("t6_src", 32'(src), 32'd1);
        chk("t6_data", 32'(dacdata), 32'h0000C0DE);
        req1 = 1'b0;
        wait_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
